event_timestamp_tagger: RTL and testbench
=========================================

Name: event_timestamp_tagger

Overview:
- Consumer of the free-running 64-bit count from timestamp_generator: tags each rising edge of a detector event line with the current timestamp.
- Buffers tags in a small FIFO and presents them on a valid/ready stream to the readout/packetizer.
- One instance per detector channel. Sits between the timestamp bus and the channel readout path.

Parameters:
- TS_WIDTH, 64, width of timestamp input and tag output.
- DEPTH, 16, FIFO entries; power of two, 2..256.
- DROP_WIDTH, 16, width of the saturating dropped-event counter.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset. Synchronous, active-low.
- run  in  1  enable event capture; FIFO drains regardless.
- timestamp  in  TS_WIDTH  current count from timestamp_generator.
- event_in  in  1  detector event line, level, active-high.
- m_valid  out  1  tag available.
- m_ready  in  1  downstream accepts tag.
- m_data  out  TS_WIDTH  tag value (head of FIFO).
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: at least one event dropped since reset.
- dropped  out  DROP_WIDTH  dropped-event count, saturating at all-ones.

Behaviour:
- Reset (resetn=0 at posedge):
  - m_valid=0, m_data=0, fill=0, overflow=0, dropped=0.
  - Edge-detect history=0.
  - Clears in-flight FIFO contents mid-operation; no tag survives reset.
- Edge detect: internal ev_q is registered from the (optionally synchronised) event line, ev_s.
  - Event detected at posedge k when ev_s=1 and ev_q=0 and run=1.
  - A level held high produces exactly one tag.
  - Events while run=0 are ignored, not counted as dropped.
  - An edge whose rising cycle has run=0 is lost, even if run rises while the line is still high.
- Capture: tag = timestamp as sampled at posedge k.
  - Pushed at posedge k; m_valid=1 after posedge k if the FIFO was empty.
  - Latency event-edge-to-m_valid: 1 cycle (without sync).
- Stream handshake:
  - Transfer when m_valid && m_ready at a posedge.
  - m_data is stable while m_valid=1 and not accepted.
  - m_valid never depends combinationally on m_ready.
  - m_data is the FIFO head; FIFO order is preserved.
- Full: push and pop in the same cycle on a full FIFO both succeed; fill unchanged; no drop.
  - Push on full without pop: event dropped; overflow<=1; dropped<=dropped+1 unless all-ones.
- Empty: pop ignored (m_valid=0). Simultaneous push on empty: fill becomes 1.
- fill counts 0..DEPTH. Read/write pointers wrap modulo DEPTH.
- The timestamp value is opaque; wrap of the 64-bit timestamp needs no special handling.

Optional Feature:
- Macro: TAGGER_EVENT_SYNC_EN.
- Defined: event_in passes through a 2-flop synchroniser before edge detect.
  - Edge-to-m_valid latency becomes 3 cycles.
  - Captured timestamp is the value at the posedge the synchronised edge is detected, i.e. 2 cycles after first sampling.
  - Synchroniser flops reset to 0.
- Undefined: event_in is assumed synchronous to clk and feeds edge detect directly; latency 1.

Decomposition:
- Package tagger_pkg: default TS_WIDTH=64, DROP_WIDTH=16, DEPTH=16.
- Sub-module tagger_sync_fifo: parameterised synchronous FIFO with push/pop/full/empty/fill, resetn-cleared pointers. The top level keeps edge detect, drop logic and counters.

Test Plan:
- Bench drives timestamp from timestamp_generator, run=1, m_ready=1.
- Single pulse:
  - event_in high one cycle when timestamp=20 -> one tag m_data=20, m_valid high next cycle only.
  - With TAGGER_EVENT_SYNC_EN, m_data=22 and m_valid 3 cycles after edge.
- Held level: event_in high 10 cycles from timestamp=30 -> exactly one tag, 30.
- Full/overflow:
  - m_ready=0, 17 single-cycle pulses spaced 2 cycles -> fill=16, overflow=1, dropped=1.
  - Then m_ready=1 -> 16 tags drain in ascending order; the 17th is absent.
- Full plus simultaneous pop: fill=16, pulse with m_ready=1 same cycle -> fill stays 16, dropped unchanged.
- run gating: run=0 with 5 pulses -> no tags, dropped=0. run=1, one pulse -> one tag.
- Reset mid-operation:
  - fill=5, resetn low 3 cycles -> m_valid=0, fill=0, overflow=0, dropped=0.
  - After release, the next pulse tags correctly.

Source files
------------

// File: rtl/tagger_pkg.sv
// Shared defaults for the event timestamp tagger slice.
package tagger_pkg;
  localparam int unsigned TAGGER_TS_WIDTH   = 64;
  localparam int unsigned TAGGER_DEPTH      = 16;
  localparam int unsigned TAGGER_DROP_WIDTH = 16;
endpackage

// File: rtl/tagger_sync_fifo.sv
// Synchronous FIFO; a push on full is accepted only when a pop happens in the same cycle.
module tagger_sync_fifo
  import tagger_pkg::*;
#(
  parameter int unsigned WIDTH = TAGGER_TS_WIDTH,
  parameter int unsigned DEPTH = TAGGER_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared, so mask the head while empty to present zero after reset.
  assign pop_data = empty ? '0 : mem[rptr];
  assign fill     = count;
endmodule

// File: rtl/event_timestamp_tagger.sv
// Tags rising edges of event_in with the current timestamp and streams the tags out.
// Define TAGGER_EVENT_SYNC_EN to pass event_in through a 2-flop synchroniser first.
module event_timestamp_tagger
  import tagger_pkg::*;
#(
  parameter int unsigned TS_WIDTH   = TAGGER_TS_WIDTH,
  parameter int unsigned DEPTH      = TAGGER_DEPTH,
  parameter int unsigned DROP_WIDTH = TAGGER_DROP_WIDTH
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    run,
  input  logic [TS_WIDTH-1:0]     timestamp,
  input  logic                    event_in,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [TS_WIDTH-1:0]     m_data,
  output logic [$clog2(DEPTH):0]  fill,
  output logic                    overflow,
  output logic [DROP_WIDTH-1:0]   dropped
);
  localparam logic [DROP_WIDTH-1:0] DROP_ONE = DROP_WIDTH'(1);

  logic ev_s;
  logic ev_q;
  logic detect;
  logic full;
  logic empty;
  logic pop;
  logic drop;

`ifdef TAGGER_EVENT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[0], event_in};
  end

  assign ev_s = sync_q[1];
`else
  assign ev_s = event_in;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) ev_q <= 1'b0;
    else         ev_q <= ev_s;
  end

  assign detect = ev_s & ~ev_q & run;
  assign pop    = m_valid & m_ready;
  // A full FIFO still takes the tag when the head leaves in the same cycle.
  assign drop   = detect & full & ~pop;

  tagger_sync_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (detect),
    .push_data (timestamp),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (full),
    .empty     (empty),
    .fill      (fill)
  );

  assign m_valid = ~empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropped != '1) dropped <= dropped + DROP_ONE;
    end
  end
endmodule

// File: tb/tb_event_timestamp_tagger.sv
// Directed bench for event_timestamp_tagger; honours TAGGER_EVENT_SYNC_EN.
module tb_event_timestamp_tagger;
`ifdef TAGGER_EVENT_SYNC_EN
  localparam int LAT    = 3;
  localparam int TS_OFF = 2;
`else
  localparam int LAT    = 1;
  localparam int TS_OFF = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic [63:0] ts = '0;
  logic        event_in;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [4:0]  fill;
  logic        overflow;
  logic [15:0] dropped;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] got[$];
  logic [63:0] exp_q[$];

  event_timestamp_tagger dut (
    .clk       (clk),
    .resetn    (resetn),
    .run       (run),
    .timestamp (ts),
    .event_in  (event_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .fill      (fill),
    .overflow  (overflow),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts <= ts + 64'd1;

  // Records each tag that will transfer at the coming posedge.
  always @(negedge clk) begin
    #1;
    if (resetn && m_valid && m_ready) got.push_back(m_data);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    event_in = 1'b1;
    @(negedge clk);
    event_in = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_ts(input logic [63:0] t);
    int n = 0;
    @(negedge clk);
    while (ts != t && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ts != t) begin errors++; $display("FAIL wait_ts: ts %0d expected %0d", ts, t); end
  endtask

  task automatic wait_got(input int n);
    int c = 0;
    while (got.size() < n && c < 100) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (got.size() < n) begin errors++; $display("FAIL drain_timeout: got %0d tags expected %0d", got.size(), n); end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    #2;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 64'd0) begin errors++; $display("FAIL reset_m_data: got %0d expected 0", m_data); end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", dropped); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_single_pulse();
    got.delete();
    wait_ts(64'd20);
    event_in = 1'b1;
    @(negedge clk);
    event_in = 1'b0;
    tick(LAT - 1);
    #2;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", m_valid); end
    checks++; if (m_data !== 64'(20 + TS_OFF)) begin errors++; $display("FAIL single_data: got %0d expected %0d", m_data, 20 + TS_OFF); end
    @(negedge clk);
    #2;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", m_valid); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL single_count: got %0d tags expected 1", got.size()); end
  endtask

  task automatic test_held_level();
    got.delete();
    wait_ts(64'd30);
    event_in = 1'b1;
    tick(10);
    event_in = 1'b0;
    tick(LAT + 3);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL held_count: got %0d tags expected 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== 64'(30 + TS_OFF)) begin errors++; $display("FAIL held_data: got %0d expected %0d", got[0], 30 + TS_OFF); end
    end
  endtask

  task automatic test_run_gating();
    logic [63:0] e;
    got.delete();
    run = 1'b0;
    repeat (5) pulse();
    tick(LAT + 2);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL gated_count: got %0d tags expected 0", got.size()); end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL gated_fill: got %0d expected 0", fill); end
    checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL gated_dropped: got %0d expected 0", dropped); end
    // run rises while the line is still high: the edge was already lost
    event_in = 1'b1;
    tick(LAT + 1);
    run = 1'b1;
    tick(3);
    event_in = 1'b0;
    tick(LAT + 3);
    checks++; if (got.size() != 0) begin errors++; $display("FAIL late_run_count: got %0d tags expected 0", got.size()); end
    e = ts + 64'(TS_OFF);
    pulse();
    tick(LAT + 2);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL run_count: got %0d tags expected 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== e) begin errors++; $display("FAIL run_data: got %0d expected %0d", got[0], e); end
    end
  endtask

  task automatic test_full_overflow();
    got.delete();
    exp_q.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(ts + 64'(TS_OFF));
      pulse();
    end
    tick(LAT + 1);
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL full_fill: got %0d expected 16", fill); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b expected 1", overflow); end
    checks++; if (dropped !== 16'd1) begin errors++; $display("FAIL full_dropped: got %0d expected 1", dropped); end
    checks++; if (m_data !== exp_q[0]) begin errors++; $display("FAIL full_head: got %0d expected %0d", m_data, exp_q[0]); end
    m_ready = 1'b1;
    wait_got(16);
    tick(3);
    checks++; if (got.size() != 16) begin errors++; $display("FAIL drain_count: got %0d tags expected 16", got.size()); end
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL drain_order[%0d]: got %0d expected %0d", i, got[i], exp_q[i]); end
    end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL drain_fill: got %0d expected 0", fill); end
  endtask

  task automatic test_full_push_pop();
    logic [63:0] e;
    exp_q.delete();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(ts + 64'(TS_OFF));
      pulse();
    end
    tick(LAT + 1);
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL pp_prefill: got %0d expected 16", fill); end
    got.delete();
    // m_ready is high only for the cycle in which the new edge is pushed
    e = ts + 64'(TS_OFF);
    event_in = 1'b1;
    if (LAT == 1) m_ready = 1'b1;
    @(negedge clk);
    event_in = 1'b0;
    if (LAT == 1) m_ready = 1'b0;
    else begin
      @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    tick(2);
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL pp_fill: got %0d expected 16", fill); end
    checks++; if (dropped !== 16'd1) begin errors++; $display("FAIL pp_dropped: got %0d expected 1", dropped); end
    checks++; if (got.size() != 1) begin errors++; $display("FAIL pp_popped: got %0d tags expected 1", got.size()); end
    m_ready = 1'b1;
    wait_got(17);
    tick(3);
    checks++; if (got.size() != 17) begin errors++; $display("FAIL pp_count: got %0d tags expected 17", got.size()); end
    if (got.size() == 17) begin
      checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL pp_first: got %0d expected %0d", got[0], exp_q[0]); end
      checks++; if (got[15] !== exp_q[15]) begin errors++; $display("FAIL pp_old_tail: got %0d expected %0d", got[15], exp_q[15]); end
      checks++; if (got[16] !== e) begin errors++; $display("FAIL pp_new_tag: got %0d expected %0d", got[16], e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    m_ready = 1'b0;
    repeat (5) pulse();
    tick(LAT + 1);
    checks++; if (fill !== 5'd5) begin errors++; $display("FAIL mid_prefill: got %0d expected 5", fill); end
    resetn = 1'b0;
    tick(3);
    #2;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 64'd0) begin errors++; $display("FAIL mid_m_data: got %0d expected 0", m_data); end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL mid_fill: got %0d expected 0", fill); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    checks++; if (dropped !== 16'd0) begin errors++; $display("FAIL mid_dropped: got %0d expected 0", dropped); end
    @(negedge clk);
    resetn = 1'b1;
    m_ready = 1'b1;
    got.delete();
    tick(2);
    e = ts + 64'(TS_OFF);
    pulse();
    tick(LAT + 2);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL post_reset_count: got %0d tags expected 1", got.size()); end
    if (got.size() > 0) begin
      checks++; if (got[0] !== e) begin errors++; $display("FAIL post_reset_data: got %0d expected %0d", got[0], e); end
    end
  endtask

  initial begin
    resetn   = 1'b0;
    run      = 1'b1;
    event_in = 1'b0;
    m_ready  = 1'b1;
    test_reset();
    test_single_pulse();
    test_held_level();
    test_run_gating();
    test_full_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
